// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC-16 serial stream encoder.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2
   } state_e;

   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   localparam logic [3:0]  IDX_MAX    = 4'd15;

endpackage

// File: rtl/crc16_lfsr.sv
// Bit-serial CRC-16 remainder register (MSB-first, non-reflected).
module crc16_lfsr
   import crc_pkg::*;
#(
   parameter logic [15:0] POLY = CRC16_POLY,
   parameter logic [15:0] INIT = CRC16_INIT
)(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        clear_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   // Next remainder: clear (frame start) wins over a data shift.
   always_comb begin
      fb    = crc_q[15] ^ bit_i;
      crc_d = crc_q;
      if (clear_i)
         crc_d = INIT;
      else if (en_i)
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
   end

   // Remainder register, reset to the seed value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) crc_q <= INIT;
      else         crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/crc16_stream_encoder.sv
// Serial encoder: passes payload bits straight through, then appends the
// complemented CRC-16 remainder MSB first, with valid/ready on both sides.
module crc16_stream_encoder
   import crc_pkg::*;
#(
   parameter logic [15:0] POLY = CRC16_POLY,
   parameter logic [15:0] INIT = CRC16_INIT
)(
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   input  logic in_bit,
   input  logic in_valid,
   input  logic in_last,
   output logic in_ready,
   output logic out_bit,
   output logic out_valid,
   input  logic out_ready,
   output logic busy,
   output logic done
);

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        done_q, done_d;
   logic        idx_clr, idx_dec;
   logic        crc_en, crc_clr;
   logic [15:0] crc;

   crc16_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .en_i    (crc_en),
      .clear_i (crc_clr),
      .bit_i   (in_bit),
      .crc_o   (crc)
   );

   // Next state and handshake outputs; payload is a zero-latency pass-through.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      idx_clr   = 1'b0;
      idx_dec   = 1'b0;
      crc_en    = 1'b0;
      crc_clr   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_bit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DATA;
               crc_clr = 1'b1;
               idx_clr = 1'b1;
            end
         end
         DATA: begin
            in_ready  = out_ready;
            out_valid = in_valid;
            out_bit   = in_bit;
            crc_en    = in_valid && out_ready;
            if (in_valid && out_ready && in_last) begin
               state_d = CRC;
               idx_clr = 1'b1;
            end
         end
         CRC: begin
            out_valid = 1'b1;
            out_bit   = ~crc[idx_q];
            if (out_ready) begin
               if (idx_q == 4'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  idx_clr = 1'b1;
               end else begin
                  idx_dec = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // CRC bit index: saturating 15-to-0 down-counter, clear reloads 15.
   always_comb begin
      idx_d = idx_q;
      if (idx_clr)
         idx_d = IDX_MAX;
      else if (idx_dec && idx_q != 4'd0)
         idx_d = idx_q - 4'd1;
   end

   // State, index and done-pulse registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= IDX_MAX;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_crc16_stream_encoder.sv
// Directed + randomized bench for crc16_stream_encoder with a long-division
// CRC reference model.
module tb_crc16_stream_encoder;

   localparam logic [15:0] POLY = 16'h8005;
   localparam logic [15:0] INIT = 16'hFFFF;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0, in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic in_ready, out_bit, out_valid, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   crc16_stream_encoder #(.POLY(POLY), .INIT(INIT)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Polynomial long division: remainder of (M(x)*x^16 + INIT*x^n) mod G(x).
   function automatic logic [15:0] ref_crc(input bit msg[$]);
      bit d[$];
      logic [16:0] g;
      logic [15:0] r;
      int n;
      n = msg.size();
      g = {1'b1, POLY};
      d = msg;
      for (int i = 0; i < 16; i++) d.push_back(1'b0);
      for (int j = 0; j < 16; j++) d[j] = d[j] ^ INIT[15-j];
      for (int i = 0; i < n; i++)
         if (d[i])
            for (int j = 0; j <= 16; j++) d[i+j] = d[i+j] ^ g[16-j];
      r = '0;
      for (int j = 0; j < 16; j++) r[15-j] = d[n+j];
      return r;
   endfunction

   function automatic logic [127:0] q2v(input bit q[$]);
      logic [127:0] v;
      v = '0;
      foreach (q[i]) v = {v[126:0], q[i]};
      return v;
   endfunction

   task automatic build_exp(input bit pl[$], output bit e[$]);
      logic [15:0] c;
      e = pl;
      c = ref_crc(pl);
      for (int i = 15; i >= 0; i--) e.push_back(~c[i]);
   endtask

   task automatic rand_pl(input int n, output bit pl[$]);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(1'($urandom_range(0, 1)));
   endtask

   // Drive one frame; collect accepted output bits. Returns in the done cycle
   // (or after abort_after output transfers when abort_after >= 0).
   task automatic run_frame(input bit pl[$], input int rdy_mode, input bit rnd_valid,
                            input bit start_noise, input int abort_after,
                            output bit got[$], output int dones, output int holds,
                            output bit timed_out);
      int k, cyc;
      bit fin, prev_stall, prev_bit;
      k = 0; cyc = 0; fin = 0; prev_stall = 0; prev_bit = 0;
      got = {}; dones = 0; holds = 0; timed_out = 0;
      @(negedge clock);
      start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      while (!fin && cyc < 2000) begin
         @(negedge clock);
         start    = start_noise && busy && ($urandom_range(0, 2) == 0);
         in_valid = (k < pl.size()) && (!rnd_valid || $urandom_range(0, 3) != 0);
         in_bit   = (k < pl.size()) ? pl[k] : 1'b0;
         in_last  = (k == pl.size() - 1);
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = ($urandom_range(0, 2) != 0);
         endcase
         #1;
         if (prev_stall && out_valid && out_bit !== prev_bit) holds++;
         prev_stall = out_valid && !out_ready;
         prev_bit   = out_bit;
         if (done) begin dones++; fin = 1; end
         if (out_valid && out_ready) got.push_back(out_bit);
         if (in_valid && in_ready) k++;
         if (abort_after >= 0 && got.size() == abort_after) fin = 1;
         cyc++;
      end
      start = 1'b0;
      if (!fin) timed_out = 1;
   endtask

   task automatic frame(input string tag, input bit pl[$], input int mode, input bit rv,
                        input bit sn, input bit tail);
      bit got[$], e[$];
      int dn, hd;
      bit to;
      run_frame(pl, mode, rv, sn, -1, got, dn, hd, to);
      build_exp(pl, e);
      check({tag, " timeout"}, 128'(to), 128'(0));
      check({tag, " len"}, 128'(got.size()), 128'(e.size()));
      check({tag, " stream"}, q2v(got), q2v(e));
      check({tag, " done"}, 128'(dn), 128'(1));
      check({tag, " hold"}, 128'(hd), 128'(0));
      if (tail) begin
         @(negedge clock); #1;
         check({tag, " idle"}, 128'({busy, done, out_valid, in_ready}), 128'(0));
      end
   endtask

   initial begin
      bit pl[$], pl2[$], got[$], e[$];
      int dn, hd;
      bit to;

      // Reset state
      #3;
      check("reset outs", 128'({in_ready, out_valid, out_bit, busy, done}), 128'(0));
      @(negedge clock); reset_n = 1'b1;
      @(negedge clock); #1;
      check("idle after reset", 128'({in_ready, out_valid, out_bit, busy, done}), 128'(0));

      // Single 0 bit: 0 then ~7FFB
      pl = {1'b0};
      run_frame(pl, 0, 0, 0, -1, got, dn, hd, to);
      check("bit0 len", 128'(got.size()), 128'(17));
      check("bit0 stream", q2v(got), 128'h0_8004);
      check("bit0 done", 128'(dn), 128'(1));
      @(negedge clock); #1;
      check("bit0 done once", 128'({done, busy}), 128'(0));

      // Single 1 bit: 1, fifteen 0s, 1
      pl = {1'b1};
      run_frame(pl, 0, 0, 0, -1, got, dn, hd, to);
      check("bit1 stream", q2v(got), 128'h1_0001);
      check("bit1 done", 128'(dn), 128'(1));
      @(negedge clock); #1;
      check("bit1 done once", 128'(done), 128'(0));

      // Single 0 bit with out_ready toggling
      pl = {1'b0};
      run_frame(pl, 1, 0, 0, -1, got, dn, hd, to);
      check("tog stream", q2v(got), 128'h0_8004);
      check("tog hold", 128'(hd), 128'(0));
      check("tog done", 128'(dn), 128'(1));
      @(negedge clock);

      // 8'hA5 with start noise and backpressure
      pl = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      frame("a5 noise", pl, 2, 1, 1, 1);

      // Reset in CRC state at idx=7
      pl = {1'b1, 1'b0, 1'b1};
      build_exp(pl, e);
      run_frame(pl, 0, 0, 0, 11, got, dn, hd, to);
      check("rst pre len", 128'(got.size()), 128'(11));
      check("rst pre stream", q2v(got), q2v(e[0:10]));
      @(negedge clock); #1;
      check("rst idx7 bit", 128'({busy, out_valid, out_bit}), 128'({1'b1, 1'b1, e[11]}));
      reset_n = 1'b0; #1;
      check("rst async outs", 128'({in_ready, out_valid, out_bit, busy, done}), 128'(0));
      @(negedge clock); reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         check("rst quiet", 128'({out_valid, busy, done}), 128'(0));
      end
      rand_pl(20, pl);
      frame("post rst", pl, 2, 1, 0, 1);

      // Back-to-back frames
      rand_pl(12, pl);
      rand_pl(9, pl2);
      frame("b2b a", pl, 0, 0, 0, 0);
      frame("b2b b", pl2, 0, 0, 0, 1);

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         rand_pl($urandom_range(1, 48), pl);
         frame($sformatf("rnd%0d", f), pl, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
